// File: rtl/instr_fetch.sv
// Fetch stage: PC, credit-limited imem requests, in-order instruction FIFO, redirect flush.
// Optional misaligned-redirect halt: define FETCH_MISALIGN_CHK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        fetch_misalign,
`endif
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int UW = CW + 1;
    localparam logic [UW-1:0] DEPTH_U = UW'(BUF_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;

    state_t                        state_q, state_d;
    logic [31:0]                   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]                 outst_q, outst_d;
    logic [CW-1:0]                 discard_q, discard_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 pend_rd_q, pend_wr_q;
    logic [BUF_DEPTH-1:0][31:0]    buf_instr_q, buf_pc_q;
    logic [BUF_DEPTH-1:0][31:0]    pend_pc_q;
    logic                          pop, rsp, grant, push;
    logic [UW-1:0]                 used;
`ifdef FETCH_MISALIGN_CHK_EN
    logic                          misalign_q, misalign_d;
    assign fetch_misalign = misalign_q;
`endif

    assign instr_valid = (count_q != '0) && (state_q != HALT);
    assign instr       = buf_instr_q[rd_ptr_q];
    assign instr_pc    = buf_pc_q[rd_ptr_q];
    assign imem_addr   = fetch_pc_q;

    assign pop   = instr_valid && instr_ready;
    assign rsp   = imem_rvalid && (outst_q != '0);
    assign grant = imem_req && imem_gnt;
    assign push  = rsp && (discard_q == '0) && !redirect_valid;
    // Credits cover buffered plus in-flight words, so a response always has a free slot.
    assign used     = UW'(count_q) + UW'(outst_q) - UW'(pop);
    assign imem_req = (state_q == FETCH) && !redirect_valid && (used < DEPTH_U);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(rsp);
        discard_d  = discard_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        if (state_q == BOOT) state_d = FETCH;
        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
        if (redirect_valid) begin
            // Everything still in flight belongs to the old path, including a same-cycle response.
            discard_d = outst_d;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end
`else
            fetch_pc_d = redirect_pc & ~32'h3;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            outst_q     <= '0;
            discard_q   <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            pend_rd_q   <= '0;
            pend_wr_q   <= '0;
            buf_instr_q <= {BUF_DEPTH{NOP}};
            buf_pc_q    <= '0;
            pend_pc_q   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pend_wr_q  <= pend_wr_q + PW'(grant);
            pend_rd_q  <= pend_rd_q + PW'(rsp);
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
            // Request addresses queue in grant order and pair with responses as they return.
            if (grant) pend_pc_q[pend_wr_q] <= fetch_pc_q;
            if (push) begin
                buf_instr_q[wr_ptr_q] <= imem_rdata;
                buf_pc_q[wr_ptr_q]    <= pend_pc_q[pend_rd_q];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order, fixed-latency instruction memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    logic        gnt_en = 1'b1;
    logic        snap_g, snap_r;
    logic [31:0] snap_a;
    logic [31:0] q_addr[$];
    int          q_cyc[$];
    int          mcyc = 0;

    assign imem_gnt = gnt_en;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    // Capture what the DUT commits at the coming edge, then update memory just after it.
    always @(negedge clk) begin
        snap_g = imem_req && imem_gnt;
        snap_r = imem_rvalid;
        snap_a = imem_addr;
    end

    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            q_addr.delete();
            q_cyc.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            if (snap_r && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_cyc.pop_front());
            end
            if (snap_g) begin
                q_addr.push_back(snap_a);
                q_cyc.push_back(mcyc);
            end
        end
        mcyc++;
        if (rst_n && q_addr.size() > 0 && q_cyc[0] + lat <= mcyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    task automatic do_reset(input int l);
        @(posedge clk);
        #1;
        rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; gnt_en = 1'b1; lat = l;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
`ifdef FETCH_MISALIGN_CHK_EN
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
`endif
    endtask

    task automatic test_stream;
        logic [31:0] ea, ep;
        do_reset(1);
        instr_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            ea = 32'(4 * (k - 1));
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== ea) begin
                errors++; $display("FAIL stream_req c%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, ea);
            end
            checks++;
            if (instr_valid !== (k >= 3)) begin
                errors++; $display("FAIL stream_valid c%0d: got %b expected %b", k, instr_valid, (k >= 3));
            end
            if (k >= 3) begin
                ep = 32'(4 * (k - 3));
                checks++;
                if (instr_pc !== ep || instr !== mem_word(ep)) begin
                    errors++; $display("FAIL stream_head c%0d: got pc=%h instr=%h expected pc=%h instr=%h", k, instr_pc, instr, ep, mem_word(ep));
                end
            end
        end
        // Asynchronous reset mid-stream, checked before the next edge.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h13) begin
            errors++; $display("FAIL async_reset: got valid=%b req=%b addr=%h instr=%h expected 0 0 0 00000013", instr_valid, imem_req, imem_addr, instr);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] ep;
        int n;
        do_reset(1);
        instr_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 3) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req c%0d: got %b expected 0", k, imem_req); end
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
                    errors++; $display("FAIL bp_hold c%0d: got valid=%b pc=%h instr=%h expected 1 0 %h", k, instr_valid, instr_pc, instr, mem_word(32'h0));
                end
            end
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        ep = 32'h0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== ep || instr !== mem_word(ep)) begin
                    errors++; $display("FAIL bp_order: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, ep, mem_word(ep));
                end
                ep += 32'd4;
                n++;
            end
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL bp_rate: got %0d pops expected 10", n); end
    endtask

    task automatic test_redirect_latency;
        logic [31:0] ep;
        int n;
        do_reset(3);
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL lat_redirect_req: got %b expected 0", imem_req); end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        ep = 32'h100;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== ep || instr !== mem_word(ep)) begin
                    errors++; $display("FAIL lat_order: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, ep, mem_word(ep));
                end
                ep += 32'd4;
                n++;
            end
        end
        checks++;
        if (n < 2) begin errors++; $display("FAIL lat_count: got %0d pops expected at least 2", n); end
    endtask

    task automatic test_redirect_same_cycle;
        logic [31:0] exp_pcs [6];
        int n;
        exp_pcs = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204, 32'h208};
        do_reset(1);
        instr_ready = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 redirect_valid = (k == 5); redirect_pc = 32'h200;
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                    errors++; $display("FAIL same_resume: got req=%b addr=%h expected 1 00000200", imem_req, imem_addr);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (n >= 6 || instr_pc !== exp_pcs[n]) begin
                    errors++; $display("FAIL same_order: pop %0d got pc=%h expected %h", n, instr_pc, (n < 6) ? exp_pcs[n] : 32'hx);
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL same_count: got %0d pops expected 6", n); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pcs [6];
        int n;
        exp_pcs = '{32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        do_reset(1);
        instr_ready = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 redirect_valid = (k == 3); redirect_pc = 32'hFFFF_FFFC;
            @(negedge clk);
            if (k == 4 || k == 5) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== ((k == 4) ? 32'hFFFF_FFFC : 32'h0)) begin
                    errors++; $display("FAIL wrap_addr c%0d: got req=%b addr=%h", k, imem_req, imem_addr);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (n >= 6 || instr_pc !== exp_pcs[n] || instr !== mem_word(instr_pc)) begin
                    errors++; $display("FAIL wrap_order: pop %0d got pc=%h instr=%h", n, instr_pc, instr);
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL wrap_count: got %0d pops expected 6", n); end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign;
        do_reset(1);
        instr_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1 redirect_valid = (k == 3); redirect_pc = 32'h102;
            @(negedge clk);
            if (k >= 4) begin
                checks++;
                if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                    errors++; $display("FAIL misalign_halt c%0d: got mis=%b req=%b valid=%b expected 1 0 0", k, fetch_misalign, imem_req, instr_valid);
                end
            end
        end
        do_reset(1);
        @(negedge clk);
        checks++;
        if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", fetch_misalign); end
    endtask
`else
    task automatic test_lowbits_ignored;
        do_reset(1);
        instr_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1 redirect_valid = (k == 3); redirect_pc = 32'h103;
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                    errors++; $display("FAIL lowbits_addr: got req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
                end
            end
            if (k == 6) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
                    errors++; $display("FAIL lowbits_head: got valid=%b pc=%h expected 1 00000100", instr_valid, instr_pc);
                end
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_same_cycle();
        test_wrap();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`else
        test_lowbits_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and issues word requests to instruction memory.
- Buffers returned words in a small in-order FIFO and presents {instr, pc} to the decoder over a valid/ready handshake.
- Accepts redirects (taken branch, jal, jalr) from the execute stage, flushing the buffer and discarding wrong-path responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction FIFO entries; also the credit limit on outstanding plus buffered words (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  control-flow change from execute.
- redirect_pc  in  32  new fetch target.
- instr_valid  out  1  buffer head valid to decoder.
- instr  out  32  buffer head instruction.
- instr_pc  out  32  PC of buffer head.
- instr_ready  in  1  decoder accepts head.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - instr_valid=0, instr=32'h0000_0013 (nop), instr_pc=0.
  - Buffer empty, outstanding=0, discard=0, state=BOOT.
- States:
  - BOOT: exits to FETCH one cycle after rst_n deasserts.
  - FETCH: normal operation.
  - HALT: only with the optional feature; exited only by reset.
- Request rule (FETCH only): imem_req=1 when buf_count + outstanding − pop < BUF_DEPTH, where pop = instr_valid & instr_ready in the same cycle.
- imem_addr always equals fetch_pc.
- On imem_req & imem_gnt: fetch_pc += 4 (mod 2^32, wraps silently); outstanding += 1.
- On imem_rvalid: outstanding −= 1.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise push {imem_rdata, pc} into the FIFO, where pc is the address of that request, tracked in order.
- No bypass: a word pushed in cycle N is visible on instr at N+1 at the earliest.
- Zero-wait memory (gnt=1, rvalid one cycle after grant) sustains 1 instr/cycle with instr_ready=1.
- instr, instr_valid and instr_pc are driven from the FIFO head.
- While instr_valid=1 and instr_ready=0, the outputs hold stable.
- Redirect (redirect_valid=1) has priority over everything in that cycle:
  - imem_req forced 0, so no new grant is possible.
  - fetch_pc ← redirect_pc.
  - FIFO cleared; a same-cycle pop still counts as consumed.
  - discard ← outstanding after including any same-cycle response, which is itself dropped.
  - instr_valid=0 from the next cycle.
  - The first request to the new target is issued the cycle after redirect.
- Back-to-back redirects: the last one wins; discard is recomputed each time.
- An imem_rvalid with outstanding=0 is a protocol error and is ignored.
- Reset mid-operation returns immediately to reset values; in-flight responses after reset are not discarded (memory is also reset).
- imem_req may drop without grant only on redirect; imem accepts this.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] ≠ 0 sets fetch_misalign=1 (sticky), enters HALT, flushes as a normal redirect, and stops requesting.
  - instr_valid stays 0 in HALT.
- Undefined:
  - No port.
  - redirect_pc[1:0] is ignored and forced to 00 in fetch_pc.

Test Plan:
- Reset release, zero-wait memory, instr_ready=1 → imem_addr sequence 0,4,8,… one per cycle; instr_pc 0,4,8 on consecutive cycles once flowing; instr_valid first high 3 cycles after rst_n rises.
- instr_ready=0 for 5 cycles → at most BUF_DEPTH words buffered, imem_req low once credits are exhausted, head holds at pc=0x0; release → in-order resumption with no loss or duplicate.
- Memory latency 3 cycles, redirect to 0x100 while 2 requests are outstanding → both stale responses dropped; next instr_pc=0x100, followed by 0x104.
- Redirect in the same cycle as imem_rvalid and a pop → that response dropped, popped instr counted once, fetch resumes at the target next cycle.
- fetch_pc=0xFFFF_FFFC → next request address 0x0000_0000.
- With FETCH_MISALIGN_CHK_EN: redirect_pc=0x102 → fetch_misalign=1, imem_req stays 0, instr_valid stays 0 until reset.
